npc_sequencer: RTL
==================

Name: npc_sequencer

Overview:
- Parametrised successor of the pipeline's nPC-select/flush logic.
- Owns the PC/nPC register pair and applies SPARC delay-slot semantics: taken branch, annulled delay slot (not-taken with a=1, or branch-always with a=1), CALL and JMPL.
- Adds a post-reset flush hold sequence, pipeline stall support and a saturating annul counter.
- Sits between the ID-stage branch/control decode and the IF-stage PC/nPC registers and IF/ID pipeline register.

Parameters:
- ADDR_W, 32, width of PC/nPC/target buses.
- RESET_PC, 0, PC value loaded on reset; nPC resets to RESET_PC+INSTR_BYTES.
- INSTR_BYTES, 4, sequential increment.
- RESET_HOLD, 2, cycles (≥1) IF_ID_R stays high after R deasserts.
- CNT_W, 16, width of the annul event counter.

Ports:
- clk  in  1  clock, rising edge
- R  in  1  synchronous active-high reset
- LE  in  1  pipeline advance enable; 0 = stall
- CALL  in  1  CALL in ID
- J  in  1  branch condition true (BR_TAKEN_ID)
- BI  in  1  branch instruction in ID (B_ID)
- BA  in  1  branch-always in ID
- J_L  in  1  JMPL in ID
- a_bit  in  1  annul bit I[29]
- TAG  in  ADDR_W  branch/CALL target
- ALU_TGT  in  ADDR_W  JMPL target from ALU
- PC  out  ADDR_W  current fetch address
- nPC  out  ADDR_W  next fetch address
- nPC_sel  out  2  00 seq, 01 TAG, 10 ALU_TGT (11 never driven)
- IF_ID_R  out  1  flush IF/ID at next edge
- busy  out  1  high while in HOLD state
- annul_cnt  out  CNT_W  saturating count of annulled delay slots

Behaviour:
- States: HOLD, RUN. R=1 at an edge: state<=HOLD, hold counter<=RESET_HOLD, PC<=RESET_PC, nPC<=RESET_PC+INSTR_BYTES, annul_cnt<=0. R has priority over every other input.
- While R=1: IF_ID_R=1, busy=1, nPC_sel=00.
- HOLD (R=0): IF_ID_R=1, busy=1, nPC_sel=00. PC/nPC frozen; LE and control inputs ignored. Counter decrements each edge; on the edge where it reaches 0, state<=RUN. IF_ID_R is therefore high for exactly RESET_HOLD cycles after R drops.
- RUN, combinational decode, first match wins:
  1. BI&J: sel=01; flush=BA&a_bit (branch-always with annul); else flush=0.
  2. BI&!J&a_bit: sel=00, flush=1.
  3. CALL: sel=01, flush=0.
  4. J_L: sel=10, flush=0.
  5. Otherwise sel=00, flush=0.
- RUN, LE=1: IF_ID_R=flush, nPC_sel=sel. At the edge: PC<=nPC; nPC<=nPC+INSTR_BYTES (sel 00), TAG (01) or ALU_TGT (10). If flush=1, annul_cnt increments, saturating at 2^CNT_W-1.
- RUN, LE=0: PC, nPC and annul_cnt hold; IF_ID_R=0; nPC_sel shows the decoded value but has no effect. The decision is re-evaluated once LE returns to 1.
- Arithmetic is modulo 2^ADDR_W: nPC=2^ADDR_W-4 advances to 0 with no error. TAG/ALU_TGT are used unmodified; alignment checking belongs to the trap logic.
- R asserted mid-branch or mid-HOLD always restarts the full reset sequence.

Test Plan:
- Reset: R=1 for 3 cycles then 0, RESET_HOLD=2 -> PC=0, nPC=4; IF_ID_R=1 and busy=1 for 2 cycles after release; first advance gives PC=4, nPC=8.
- Taken branch: PC=0x10, nPC=0x14, BI=J=1, a=1, BA=0, TAG=0x100 -> IF_ID_R=0; next PC=0x14, nPC=0x100; annul_cnt unchanged.
- Annul cases:
  - BI=1, J=0, a=1 -> IF_ID_R=1, nPC_sel=00, annul_cnt+1.
  - BA=1, J=1, a=1, TAG=0x200 -> IF_ID_R=1, nPC=0x200, annul_cnt+1.
- Precedence/JMPL: CALL=1 and J_L=1 together, TAG=0x40, ALU_TGT=0x80 -> nPC_sel=01, nPC=0x40. J_L alone -> nPC_sel=10, nPC=0x80.
- Stall: LE=0 for 3 cycles during BI=1, J=0, a=1 -> PC/nPC frozen, IF_ID_R=0; on LE=1 the flush and counter increment occur exactly once.
- Wrap and saturation:
  - nPC=0xFFFFFFFC sequential -> nPC becomes 0x00000000.
  - CNT_W=2 with 5 annuls -> annul_cnt=3.
  - R mid-HOLD -> HOLD restarts with full RESET_HOLD.

Source files
------------

// File: rtl/npc_sequencer_if.sv
// Control/target bundle between ID-stage decode and the nPC sequencer.
// master = decode side (drives controls), slave = sequencer.
interface npc_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
);
   logic              LE;
   logic              CALL;
   logic              J;
   logic              BI;
   logic              BA;
   logic              J_L;
   logic              a_bit;
   logic [ADDR_W-1:0] TAG;
   logic [ADDR_W-1:0] ALU_TGT;
   logic [ADDR_W-1:0] PC;
   logic [ADDR_W-1:0] nPC;
   logic [1:0]        nPC_sel;
   logic              IF_ID_R;
   logic              busy;
   logic [CNT_W-1:0]  annul_cnt;

   modport master (
      output LE, CALL, J, BI, BA, J_L, a_bit, TAG, ALU_TGT,
      input  PC, nPC, nPC_sel, IF_ID_R, busy, annul_cnt
   );
   modport slave (
      input  LE, CALL, J, BI, BA, J_L, a_bit, TAG, ALU_TGT,
      output PC, nPC, nPC_sel, IF_ID_R, busy, annul_cnt
   );
endinterface

// File: rtl/npc_sequencer.sv
// PC/nPC owner with SPARC delay-slot handling, post-reset flush hold,
// stall support and a saturating annulled-slot counter.
module npc_sequencer #(
   parameter int ADDR_W      = 32,
   parameter int RESET_PC    = 0,
   parameter int INSTR_BYTES = 4,
   parameter int RESET_HOLD  = 2,
   parameter int CNT_W       = 16
) (
   input logic            clk,
   input logic            R,
   npc_sequencer_if.slave bus
);
   localparam int HOLD_W = (RESET_HOLD < 1) ? 1 : $clog2(RESET_HOLD + 1);
   localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] RST_NPC = ADDR_W'(RESET_PC + INSTR_BYTES);
   localparam logic [ADDR_W-1:0] INC     = ADDR_W'(INSTR_BYTES);

   typedef enum logic {HOLD, RUN} state_e;

   state_e            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] npc_q, npc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        sel;
   logic              flush;
   logic [1:0]        sel_out;
   logic              if_id_r;
   logic              busy;

   // Delay-slot decode; first match wins.
   always_comb begin
      sel   = 2'b00;
      flush = 1'b0;
      if (bus.BI && bus.J) begin
         sel   = 2'b01;
         flush = bus.BA && bus.a_bit;
      end else if (bus.BI && bus.a_bit) begin
         flush = 1'b1;
      end else if (bus.CALL) begin
         sel = 2'b01;
      end else if (bus.J_L) begin
         sel = 2'b10;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      pc_d    = pc_q;
      npc_d   = npc_q;
      cnt_d   = cnt_q;
      if (R || state_q == HOLD) begin
         sel_out = 2'b00;
         if_id_r = 1'b1;
         busy    = 1'b1;
      end else begin
         sel_out = sel;
         if_id_r = bus.LE && flush;
         busy    = 1'b0;
      end
      if (state_q == HOLD) begin
         hold_d = hold_q - HOLD_W'(1);
         if (hold_q <= HOLD_W'(1)) state_d = RUN;
      end else if (bus.LE) begin
         pc_d = npc_q;
         unique case (sel)
            2'b01:   npc_d = bus.TAG;
            2'b10:   npc_d = bus.ALU_TGT;
            default: npc_d = npc_q + INC;
         endcase
         if (flush && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (R) begin
         state_q <= HOLD;
         hold_q  <= HOLD_W'(RESET_HOLD);
         pc_q    <= RST_PC;
         npc_q   <= RST_NPC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         pc_q    <= pc_d;
         npc_q   <= npc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.PC        = pc_q;
   assign bus.nPC       = npc_q;
   assign bus.nPC_sel   = sel_out;
   assign bus.IF_ID_R   = if_id_r;
   assign bus.busy      = busy;
   assign bus.annul_cnt = cnt_q;
endmodule
